gf180mcu_shared_buf_arbiter: RTL and testbench
==============================================

# gf180mcu_shared_buf_arbiter

Round-robin arbiter that shares one strong output buffer (a 4x-drive `buf` cell on a shared net) among N requesters. It selects one requester, registers that requester's data onto the buffer input and asserts the buffer enable. Every hand-over inserts a minimum hold period and a turnaround gap, so two drivers never contend on the shared net. It sits between requester logic and the shared-buffer instance in the pad/driver ring.

## Interface
Parameters:
- `N`, 4: number of requesters; range 2..16.
- `HOLD`, 2: minimum grant length in cycles; at least 1.
- `TURN`, 1: turnaround cycles with nothing driven between grants; at least 1.
- `MAXG`, 8: grant length after which the grant is preempted if another requester is waiting; must be at least `HOLD`.

Ports:
- `CLK` input, 1: the only clock; all state updates on the rising edge.
- `RST` input, 1: synchronous, active-high reset.
- `REQ` input, N: per-requester request level.
- `DATA` input, N: per-requester data bit to drive.
- `GNT` output, N: one-hot grant, registered.
- `BUF_I` output, 1: registered data to the shared buffer `I` pin.
- `BUF_EN` output, 1: registered; high while a requester owns the buffer.
- `BUSY` output, 1: high in DRIVE or TURN.

## Operation
- Reset values: state IDLE, `GNT`=0, `BUF_EN`=0, `BUF_I`=0, `BUSY`=0, `PTR`=0, `cnt`=0, `tcnt`=0.
- Reset mid-operation: the next edge forces the reset values. No turnaround is inserted.
- Arbitration:
  - Winner = first set bit of `REQ`, scanning from index `PTR` upward and wrapping modulo N.
  - On grant: `PTR` <= winner+1 mod N.
- IDLE:
  - If any `REQ` is high: go to DRIVE with `g`=winner, `GNT`=1<<g, `BUF_EN`=1, `BUF_I`<=`DATA[g]`, `cnt`=1.
  - Otherwise stay in IDLE with outputs at 0.
- DRIVE:
  - Each cycle: `BUF_I`<=`DATA[g]`. `cnt` increments and saturates at `MAXG`.
  - Release at the end of the current cycle when either:
    - `REQ[g]`=0 and `cnt`>=`HOLD`, or
    - `cnt`>=`MAXG` and any other `REQ` bit is high.
  - If `REQ[g]` drops before `HOLD`, the grant is held until `cnt`=`HOLD`.
  - On release: next state TURN with `GNT`=0, `BUF_EN`=0, `BUF_I`=0, `tcnt`=1.
- TURN:
  - Outputs stay at 0 and `BUSY`=1.
  - While `tcnt`<`TURN`, `tcnt` increments.
  - On the cycle `tcnt`=`TURN`: arbitrate exactly as in IDLE. If any `REQ` is high, go to DRIVE; otherwise go to IDLE.
- `GNT` is never non-zero in two consecutive grants without at least `TURN` zero cycles between them.
- `GNT` always has at most one bit set.
- `BUF_EN` equals the OR-reduction of `GNT`.

## Timing
- Request to grant: `REQ` sampled at edge t gives `GNT` valid after edge t (1-cycle latency).
- Data: `BUF_I` equals `DATA[g]` sampled one edge earlier.
- Grant length: minimum `HOLD` cycles. If others are waiting, maximum `MAXG` cycles; otherwise unbounded.
- Gap between grants: exactly `TURN` cycles when a request is pending.
- Simultaneous requests are resolved in one cycle by the `PTR` rotation. A requester that releases and re-requests waits behind other pending requesters.
- `REQ` of non-granted requesters may change freely. Only `REQ[g]` affects release, apart from the preemption check.

## Structure
- Shared package `gf180mcu_shared_buf_pkg`:
  - state enum: IDLE, DRIVE, TURN;
  - width constants: `IDXW`=$clog2(N), `CNTW`=$clog2(MAXG+1), `TCNTW`=$clog2(TURN+1).
- One sub-module, `gf180mcu_shared_buf_rr_pick`: combinational rotate-priority-encode. Inputs `REQ` and `PTR`; outputs winner index and valid.
- Top level holds the FSM, the counters, the `PTR` register and the output registers.

## Test plan
All cases use N=4, HOLD=2, TURN=1, MAXG=8.
- **Reset:** assert `RST` for 2 cycles with `REQ`=1111 -> `GNT`=0000, `BUF_EN`=0, `BUF_I`=0, `BUSY`=0 throughout. The first grant after release is `GNT`=0001.
- **Short request:** `REQ[2]` pulses for 1 cycle at edge 5 -> `GNT`=0100 after edges 5 and 6 (HOLD=2), 0000 after edge 7 with `BUSY`=1, IDLE after edge 8.
- **Fair rotation:** `REQ`=1111 held constant -> grants 0001, 0010, 0100, 1000, 0001. Each grant lasts 8 cycles and is followed by a 1-cycle gap, giving a 9-cycle period.
- **Preemption:** `REQ[1]` held high, `REQ[3]` rises during cycle 3 of that grant -> `GNT`=0010 for exactly 8 cycles, 1 gap cycle, then `GNT`=1000.
- **Data path:** during a grant to 0, toggle `DATA[0]` 1,0,1 -> `BUF_I` follows 1 cycle later. `BUF_I`=0 in the TURN cycle. Toggling `DATA[1..3]` has no effect.
- **Reset mid-drive:** assert `RST` in cycle 4 of a grant -> at the next edge `GNT`=0, `BUF_EN`=0, `PTR`=0, with no TURN cycle.

Source files
------------

// File: rtl/gf180mcu_shared_buf_pkg.sv
// Shared types and width helpers for the shared-buffer arbiter.
// Width constants below describe the default N=4 / MAXG=8 / TURN=1 configuration.
package gf180mcu_shared_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  localparam int DEF_N    = 4;
  localparam int DEF_HOLD = 2;
  localparam int DEF_TURN = 1;
  localparam int DEF_MAXG = 8;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int maxg);
    return $clog2(maxg + 1);
  endfunction

  function automatic int tcnt_w(input int turn);
    return $clog2(turn + 1);
  endfunction

  localparam int IDXW  = idx_w(DEF_N);
  localparam int CNTW  = cnt_w(DEF_MAXG);
  localparam int TCNTW = tcnt_w(DEF_TURN);

endpackage

// File: rtl/gf180mcu_shared_buf_rr_pick.sv
// Rotating priority encoder: first set request at or above i_ptr, wrapping modulo N.
module gf180mcu_shared_buf_rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [IDXW-1:0] o_idx,
  output logic            o_valid
);

  int w_j;

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    w_j     = 0;
    // Scan from the farthest offset back toward i_ptr so the nearest request wins.
    for (int k = N - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (i_req[IDXW'(w_j)]) o_idx = IDXW'(w_j);
    end
  end

endmodule

// File: rtl/gf180mcu_shared_buf_arbiter.sv
// Round-robin owner selection for one shared output buffer, with a minimum hold,
// preemption after MAXG cycles and a TURN-cycle undriven gap between owners.
module gf180mcu_shared_buf_arbiter
  import gf180mcu_shared_buf_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int HOLD = DEF_HOLD,
  parameter int TURN = DEF_TURN,
  parameter int MAXG = DEF_MAXG
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [N-1:0] REQ,
  input  logic [N-1:0] DATA,
  output logic [N-1:0] GNT,
  output logic         BUF_I,
  output logic         BUF_EN,
  output logic         BUSY
);

  localparam int IW = idx_w(N);
  localparam int CW = cnt_w(MAXG);
  localparam int TW = tcnt_w(TURN);

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD);
  localparam logic [CW-1:0] MAXG_C = CW'(MAXG);
  localparam logic [TW-1:0] TURN_C = TW'(TURN);
  localparam logic [IW-1:0] LAST_C = IW'(N - 1);

  state_t         r_state, w_state_next;
  logic [N-1:0]   r_gnt, w_gnt_next;
  logic           r_buf_i, w_buf_i_next;
  logic           r_buf_en, w_buf_en_next;
  logic [IW-1:0]  r_ptr, w_ptr_next;
  logic [IW-1:0]  r_g, w_g_next;
  logic [CW-1:0]  r_cnt, w_cnt_next;
  logic [TW-1:0]  r_tcnt, w_tcnt_next;

  logic [IW-1:0]  w_pick_idx;
  logic           w_pick_valid;
  logic [IW-1:0]  w_pick_inc;
  logic [N-1:0]   w_pick_onehot;
  logic           w_others;
  logic           w_release;
  logic           w_arb;

  gf180mcu_shared_buf_rr_pick #(
    .N    (N),
    .IDXW (IW)
  ) u_pick (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_pick_inc    = (w_pick_idx == LAST_C) ? '0 : w_pick_idx + IW'(1);
  assign w_pick_onehot = {{(N-1){1'b0}}, 1'b1} << w_pick_idx;

  // In DRIVE r_gnt is exactly the owner's bit, so masking it leaves the waiters.
  assign w_others  = |(REQ & ~r_gnt);
  assign w_release = (!REQ[r_g] && (r_cnt >= HOLD_C)) ||
                     ((r_cnt >= MAXG_C) && w_others);

  always_comb begin
    w_state_next  = r_state;
    w_gnt_next    = r_gnt;
    w_buf_i_next  = r_buf_i;
    w_buf_en_next = r_buf_en;
    w_ptr_next    = r_ptr;
    w_g_next      = r_g;
    w_cnt_next    = r_cnt;
    w_tcnt_next   = r_tcnt;
    w_arb         = 1'b0;

    case (r_state)
      ST_IDLE: w_arb = 1'b1;
      ST_DRIVE: begin
        if (w_release) begin
          w_state_next  = ST_TURN;
          w_gnt_next    = '0;
          w_buf_en_next = 1'b0;
          w_buf_i_next  = 1'b0;
          w_tcnt_next   = TW'(1);
        end else begin
          w_buf_i_next = DATA[r_g];
          if (r_cnt < MAXG_C) w_cnt_next = r_cnt + CW'(1);
        end
      end
      ST_TURN: begin
        if (r_tcnt < TURN_C) w_tcnt_next = r_tcnt + TW'(1);
        else                 w_arb       = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase

    if (w_arb) begin
      w_gnt_next    = '0;
      w_buf_en_next = 1'b0;
      w_buf_i_next  = 1'b0;
      if (w_pick_valid) begin
        w_state_next  = ST_DRIVE;
        w_g_next      = w_pick_idx;
        w_gnt_next    = w_pick_onehot;
        w_buf_en_next = 1'b1;
        w_buf_i_next  = DATA[w_pick_idx];
        w_cnt_next    = CW'(1);
        w_ptr_next    = w_pick_inc;
      end else begin
        w_state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_gnt    <= '0;
      r_buf_i  <= 1'b0;
      r_buf_en <= 1'b0;
      r_ptr    <= '0;
      r_g      <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_gnt    <= w_gnt_next;
      r_buf_i  <= w_buf_i_next;
      r_buf_en <= w_buf_en_next;
      r_ptr    <= w_ptr_next;
      r_g      <= w_g_next;
      r_cnt    <= w_cnt_next;
      r_tcnt   <= w_tcnt_next;
    end
  end

  assign GNT    = r_gnt;
  assign BUF_I  = r_buf_i;
  assign BUF_EN = r_buf_en;
  assign BUSY   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gf180mcu_shared_buf_arbiter.sv
// Bench for the shared-buffer arbiter: vector table, directed corner sequences,
// and randomized traffic against a cycle-level ownership model.
module tb_gf180mcu_shared_buf_arbiter;

  localparam int N    = 4;
  localparam int HOLD = 2;
  localparam int TURN = 1;
  localparam int MAXG = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] data = '0;
  logic [N-1:0] gnt;
  logic         buf_i;
  logic         buf_en;
  logic         busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the buffer, for how long, and turnaround progress.
  int   m_owner = -1;
  int   m_len   = 0;
  int   m_gap   = 0;
  int   m_ptr   = 0;
  logic m_bi    = 1'b0;

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] data;
    logic [N-1:0] gnt;
    logic         en;
    logic         bi;
    logic         busy;
  } vec_t;

  vec_t vecs [13];

  gf180mcu_shared_buf_arbiter #(
    .N    (N),
    .HOLD (HOLD),
    .TURN (TURN),
    .MAXG (MAXG)
  ) dut (
    .CLK    (clk),
    .RST    (rst),
    .REQ    (req),
    .DATA   (data),
    .GNT    (gnt),
    .BUF_I  (buf_i),
    .BUF_EN (buf_en),
    .BUSY   (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_try(input logic [N-1:0] q, input logic [N-1:0] d);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (q[i]) begin
        m_owner = i;
        m_len   = 1;
        m_ptr   = (i + 1) % N;
        m_bi    = d[i];
        break;
      end
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    bit rel;
    if (r) begin
      m_owner = -1; m_len = 0; m_gap = 0; m_ptr = 0; m_bi = 1'b0;
    end else if (m_owner >= 0) begin
      rel = (!q[m_owner] && m_len >= HOLD) ||
            (m_len >= MAXG && (q & ~(4'b0001 << m_owner)) != 4'b0000);
      if (rel) begin
        m_owner = -1; m_gap = 1; m_bi = 1'b0;
      end else begin
        if (m_len < MAXG) m_len++;
        m_bi = d[m_owner];
      end
    end else if (m_gap > 0 && m_gap < TURN) begin
      m_gap++;
    end else begin
      m_gap = 0;
      model_try(q, d);
    end
  endtask

  // Drive inputs, clock one edge, advance the model, then settle away from the edge.
  task automatic apply(input logic r, input logic [N-1:0] q, input logic [N-1:0] d);
    rst = r; req = q; data = d;
    @(posedge clk);
    model_step(r, q, d);
    #1;
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("rnd_gnt",  32'(gnt), 32'(eg));
    chk("rnd_en",   32'(buf_en), 32'(m_owner >= 0));
    chk("rnd_bufi", 32'(buf_i), 32'((m_owner >= 0) ? m_bi : 1'b0));
    chk("rnd_busy", 32'(busy), 32'(m_owner >= 0 || m_gap > 0));
    chk("onehot",   32'($onehot0(gnt)), 32'd1);
    chk("en_or",    32'(buf_en), 32'(|gnt));
  endtask

  initial begin
    logic [N-1:0] rnd;
    logic [N-1:0] q;
    logic [N-1:0] eg;
    logic         r;

    //                 rst   req    data   gnt    en    bi    busy
    vecs[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'hF, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'h4, 4'h4, 4'h4, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 4'h0, 4'h0, 4'h4, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'h1, 4'h1, 4'h1, 1'b1, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 4'hF, 4'h0, 4'h1, 1'b1, 1'b0, 1'b1};

    for (int v = 0; v < 13; v++) begin
      apply(vecs[v].rst, vecs[v].req, vecs[v].data);
      chk($sformatf("vec%0d_gnt", v),  32'(gnt),    32'(vecs[v].gnt));
      chk($sformatf("vec%0d_en", v),   32'(buf_en), 32'(vecs[v].en));
      chk($sformatf("vec%0d_bufi", v), 32'(buf_i),  32'(vecs[v].bi));
      chk($sformatf("vec%0d_busy", v), 32'(busy),   32'(vecs[v].busy));
      $display("vec %0d: rst=%b req=%b data=%b -> gnt=%b en=%b bi=%b busy=%b",
               v, vecs[v].rst, vecs[v].req, vecs[v].data, gnt, buf_en, buf_i, busy);
    end

    // Fair rotation: 8-cycle grants, 1-cycle gaps, owners 0,1,2,3,0.
    apply(1'b1, 4'h0, 4'h0);
    apply(1'b1, 4'h0, 4'h0);
    for (int c = 0; c < 45; c++) begin
      rnd = 4'($urandom);
      apply(1'b0, 4'hF, rnd);
      eg = ((c % 9) < 8) ? (4'b0001 << ((c / 9) % 4)) : 4'b0000;
      chk($sformatf("rot_gnt_c%0d", c), 32'(gnt), 32'(eg));
      $display("rotation cycle %0d: gnt=%b", c, gnt);
    end

    // Preemption: owner 1 keeps requesting, requester 3 arrives in grant cycle 3.
    apply(1'b1, 4'h0, 4'h0);
    for (int c = 1; c <= 10; c++) begin
      q  = (c < 3) ? 4'b0010 : 4'b1010;
      apply(1'b0, q, 4'h0);
      eg = (c <= 8) ? 4'b0010 : ((c == 9) ? 4'b0000 : 4'b1000);
      chk($sformatf("pre_gnt_c%0d", c), 32'(gnt), 32'(eg));
      chk($sformatf("pre_busy_c%0d", c), 32'(busy), 32'd1);
      $display("preempt cycle %0d: req=%b gnt=%b busy=%b", c, q, gnt, busy);
    end

    // Data path: only DATA[0] reaches the buffer while requester 0 owns it.
    apply(1'b1, 4'h0, 4'h0);
    for (int s = 0; s < 3; s++) begin
      rnd = 4'($urandom);
      r   = (s != 1);
      apply(1'b0, 4'b0001, {rnd[3:1], r});
      chk($sformatf("data_bufi_s%0d", s), 32'(buf_i), 32'(r));
      chk($sformatf("data_gnt_s%0d", s), 32'(gnt), 32'h1);
      $display("data step %0d: data=%b -> bufi=%b", s, {rnd[3:1], r}, buf_i);
    end
    apply(1'b0, 4'h0, 4'hF);
    chk("data_turn_bufi", 32'(buf_i), 32'd0);
    chk("data_turn_busy", 32'(busy), 32'd1);
    $display("data turn: bufi=%b busy=%b", buf_i, busy);
    apply(1'b0, 4'h0, 4'hF);
    chk("data_idle_busy", 32'(busy), 32'd0);

    // Reset in grant cycle 4: immediate idle, pointer back to 0, no turnaround.
    apply(1'b1, 4'h0, 4'h0);
    for (int c = 1; c <= 4; c++) apply(1'b0, 4'b0100, 4'hF);
    chk("mid_pre_gnt", 32'(gnt), 32'h4);
    apply(1'b1, 4'b0100, 4'hF);
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_en", 32'(buf_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    apply(1'b0, 4'hF, 4'h0);
    chk("mid_ptr0_gnt", 32'(gnt), 32'h1);
    $display("reset mid-drive: gnt after release=%b", gnt);

    // Randomized traffic against the ownership model.
    apply(1'b1, 4'h0, 4'h0);
    q = '0;
    for (int t = 0; t < 3000; t++) begin
      r = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        q = 4'($urandom);
        if ($urandom_range(0, 1) == 1) q = q & 4'($urandom);
      end
      rnd = 4'($urandom);
      apply(r, q, rnd);
      check_model();
      if (t % 100 == 0)
        $display("random %0d: rst=%b req=%b data=%b gnt=%b bi=%b busy=%b",
                 t, r, q, rnd, gnt, buf_i, busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
